// File: rtl/song_loader.sv
// Serial song loader: 8N1 UART receiver feeding a framed-image parser that
// emits one-cycle write strobes into the 24-bit {song, offset} song memory.
module song_loader #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        wr_en,
    output logic [23:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [1:0]  song,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        F_IDLE,
        F_SONG,
        F_LEN2,
        F_LEN1,
        F_LEN0,
        F_DATA,
        F_CSUM
    } frame_state_t;

    logic [1:0]       sync_q;
    logic             rx_prev_q;
    logic             rx_s;

    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_stb;
    logic             frame_err;

    frame_state_t     state_q;
    logic [21:0]      len_q;
    logic [21:0]      offset_q;
    logic [7:0]       acc_q;
    logic             wr_en_q;
    logic [23:0]      wr_addr_q;
    logic [7:0]       wr_data_q;
    logic [1:0]       song_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], rx};
            rx_prev_q <= rx_s;
        end
    end

    // Bit timing is counted from the synced falling edge; the stop bit is
    // resolved combinationally so the parser acts on the very sampling edge.
    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_stb   = 1'b0;
        frame_err  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s && rx_prev_q) begin
                    rx_state_d = RX_START;
                    cnt_d      = CNT_W'(1);
                end
            end
            RX_START: begin
                if (cnt_q == CNT_HALF_END) begin
                    cnt_d = '0;
                    bit_d = 3'd0;
                    if (rx_s) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_BIT_END) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_BIT_END) begin
                    cnt_d      = '0;
                    byte_stb   = rx_s;
                    frame_err  = !rx_s;
                    rx_state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'd0;
        end else begin
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= F_IDLE;
            len_q     <= 22'd0;
            offset_q  <= 22'd0;
            acc_q     <= 8'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 24'd0;
            wr_data_q <= 8'd0;
            song_q    <= 2'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            if (frame_err && busy_q) begin
                state_q <= F_IDLE;
                busy_q  <= 1'b0;
                error_q <= 1'b1;
            end else if (byte_stb) begin
                case (state_q)
                    F_IDLE: begin
                        if (shift_q == HEADER) begin
                            state_q  <= F_SONG;
                            busy_q   <= 1'b1;
                            done_q   <= 1'b0;
                            error_q  <= 1'b0;
                            acc_q    <= 8'd0;
                            offset_q <= 22'd0;
                        end
                    end
                    F_SONG: begin
                        if (shift_q > 8'd3) begin
                            state_q <= F_IDLE;
                            busy_q  <= 1'b0;
                            error_q <= 1'b1;
                        end else begin
                            song_q  <= shift_q[1:0];
                            state_q <= F_LEN2;
                        end
                    end
                    F_LEN2: begin
                        if (shift_q[7:6] != 2'b00) begin
                            state_q <= F_IDLE;
                            busy_q  <= 1'b0;
                            error_q <= 1'b1;
                        end else begin
                            len_q[21:16] <= shift_q[5:0];
                            state_q      <= F_LEN1;
                        end
                    end
                    F_LEN1: begin
                        len_q[15:8] <= shift_q;
                        state_q     <= F_LEN0;
                    end
                    F_LEN0: begin
                        len_q[7:0] <= shift_q;
                        offset_q   <= 22'd0;
                        acc_q      <= 8'd0;
                        if ({len_q[21:8], shift_q} == 22'd0) begin
                            state_q <= F_CSUM;
                        end else begin
                            state_q <= F_DATA;
                        end
                    end
                    F_DATA: begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= {song_q, offset_q};
                        wr_data_q <= shift_q;
                        acc_q     <= acc_q ^ shift_q;
                        offset_q  <= offset_q + 22'd1;
                        // Comparing the incremented offset keeps offset from ever wrapping.
                        if (offset_q + 22'd1 == len_q) begin
                            state_q <= F_CSUM;
                        end
                    end
                    F_CSUM: begin
                        state_q <= F_IDLE;
                        busy_q  <= 1'b0;
                        if (shift_q == acc_q) begin
                            done_q <= 1'b1;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                    default: state_q <= F_IDLE;
                endcase
            end
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign song    = song_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = error_q;

endmodule

// File: tb/tb_song_loader.sv
// Testbench for song_loader: directed frames plus randomized frames checked
// against a frame-level reference model of expected writes and final status.
module tb_song_loader;

    localparam int C = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic        wr_en;
    logic [23:0] wr_addr;
    logic [7:0]  wr_data;
    logic [1:0]  song;
    logic        busy;
    logic        done;
    logic        error;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [1:0]  m_song = 2'd0;
    logic        prev_wr = 1'b0;

    always #5 clk = ~clk;

    song_loader #(.CLKS_PER_BIT(C), .HEADER(8'hA5)) dut (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .song    (song),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every write strobe is matched in order against the model's expectations.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            chk("wr_gap", {31'd0, prev_wr}, 32'd0);
            if (exp_q.size() == 0) chk("wr_extra", {31'd0, wr_en}, 32'd0);
            else chk("wr_addr_data", {wr_addr, wr_data}, exp_q.pop_front());
        end
        prev_wr = wr_en;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat (C) @(posedge clk);
            #1;
        end
        rx = 1'b1;
    endtask

    task automatic chk_status(input string tag, input logic eb, input logic ed, input logic ee);
        chk({tag, "_busy"},  {31'd0, busy},  {31'd0, eb});
        chk({tag, "_done"},  {31'd0, done},  {31'd0, ed});
        chk({tag, "_error"}, {31'd0, error}, {31'd0, ee});
    endtask

    // Reference: work out from the byte list where the frame ends, what gets
    // written, and the final status; then transmit and compare.
    task automatic run_frame(input string tag, input logic [7:0] fr[$], input int fe_idx, input bit gaps);
        int         n;
        int         a;
        int         len;
        int         last;
        logic [7:0] cs;
        logic       aborted;
        logic       e_done;
        n  = fr.size();
        a  = n;
        cs = 8'd0;
        if (fe_idx >= 1 && fe_idx < a) a = fe_idx;
        if (n > 1 && fr[1] > 8'd3 && a > 1) a = 1;
        if (n > 2 && fr[2][7:6] != 2'b00 && a > 2) a = 2;
        len = (n > 4) ? int'({fr[2], fr[3], fr[4]}) : 0;
        for (int j = 5; j < 5 + len && j < a && j < n; j++) begin
            exp_q.push_back({fr[1][1:0], 22'(j - 5), fr[j]});
            cs = cs ^ fr[j];
        end
        if (a > 1) m_song = fr[1][1:0];
        aborted = (a < n);
        e_done  = !aborted && (fr[5 + len] == cs);
        last    = aborted ? a : n - 1;
        for (int i = 0; i <= last; i++) begin
            send_byte(fr[i], (i != fe_idx));
            if (i == 0 && last > 0) chk_status({tag, "_hdr"}, 1'b1, 1'b0, 1'b0);
            if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, C));
        end
        idle(4);
        chk_status(tag, 1'b0, e_done, !e_done);
        chk({tag, "_song"}, {30'd0, song}, {30'd0, m_song});
        chk({tag, "_pending"}, exp_q.size(), 32'd0);
        exp_q.delete();
        idle(2 * C);
    endtask

    logic [7:0] nom[$]   = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h44, 8'h77};
    logic [7:0] badcs[$] = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h44, 8'h76};
    logic [7:0] badsg[$] = '{8'hA5, 8'h04, 8'h00, 8'h00, 8'h01, 8'h55, 8'h55};
    logic [7:0] badl2[$] = '{8'hA5, 8'h02, 8'h40, 8'h00, 8'h01, 8'h55, 8'h55};
    logic [7:0] zero0[$] = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] zero1[$] = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01};

    initial begin
        logic [7:0] fr[$];
        logic [7:0] cs;
        logic [7:0] sb;
        int         len;
        int         fe;

        reset = 1'b1;
        rx    = 1'b1;
        #1;
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_addr_data", {wr_addr, wr_data}, 32'd0);
        chk("rst_song", {30'd0, song}, 32'd0);
        chk_status("rst", 1'b0, 1'b0, 1'b0);
        idle(3);
        reset = 1'b0;
        idle(2 * C);

        run_frame("nominal", nom, -1, 1'b0);
        run_frame("csum_bad", badcs, -1, 1'b0);
        run_frame("after_err", nom, -1, 1'b0);
        run_frame("song_bad", badsg, -1, 1'b0);
        run_frame("len2_bad", badl2, -1, 1'b0);
        run_frame("zero_len", zero0, -1, 1'b0);
        run_frame("zero_len_bad", zero1, -1, 1'b0);
        run_frame("stop_err", nom, 6, 1'b0);

        // A short low glitch must not be taken as a start bit.
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(4 * C);
        chk_status("glitch", 1'b0, 1'b0, 1'b1);
        run_frame("post_glitch", nom, -1, 1'b0);

        // Asynchronous reset after the second data byte.
        exp_q.push_back({2'd1, 22'd0, 8'h11});
        exp_q.push_back({2'd1, 22'd1, 8'h22});
        for (int i = 0; i <= 6; i++) send_byte(nom[i], 1'b1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("arst_addr_data", {wr_addr, wr_data}, 32'd0);
        chk("arst_song", {30'd0, song}, 32'd0);
        chk_status("arst", 1'b0, 1'b0, 1'b0);
        chk("arst_pending", exp_q.size(), 32'd0);
        exp_q.delete();
        m_song = 2'd0;
        idle(2);
        reset = 1'b0;
        idle(2 * C);
        run_frame("after_rst", nom, -1, 1'b0);

        for (int k = 0; k < 14; k++) begin
            fr.delete();
            sb  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
            len = $urandom_range(0, 5);
            fr.push_back(8'hA5);
            fr.push_back(sb);
            fr.push_back(($urandom_range(0, 9) == 0) ? 8'h40 : 8'h00);
            fr.push_back(8'h00);
            fr.push_back(8'(len));
            cs = 8'd0;
            for (int j = 0; j < len; j++) begin
                fr.push_back(8'($urandom_range(0, 255)));
                cs = cs ^ fr[5 + j];
            end
            if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
            fr.push_back(cs);
            fe = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, fr.size() - 1)) : -1;
            run_frame($sformatf("rand%0d", k), fr, fe, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/song_loader.md
# song_loader

Serial song loader: the write-side counterpart of the player's song-memory read path. It receives a framed song image over an 8N1 UART line and emits one-cycle write strobes `{wr_addr, wr_data}` into the 24-bit song memory. The memory address is `{song[1:0], offset[21:0]}`, the same layout the player reads back. It sits between the board serial pin and the writable song memory, and reports `busy`, `done` and `error` for the front panel.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clk cycles per UART bit (50 MHz / 115200); minimum 8.
- `HEADER`, default 8'hA5: frame start byte.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `rx`  in  1  UART serial input; idle high.
- `wr_en`  out  1  one-cycle memory write strobe.
- `wr_addr`  out  24  `{song, offset}` write address.
- `wr_data`  out  8  write data byte.
- `song`  out  2  song index of the current or last frame.
- `busy`  out  1  frame in progress.
- `done`  out  1  last frame completed with a good checksum.
- `error`  out  1  last frame aborted.

## Operation
- **RX front end**
  - `rx` passes through a 2-flop synchronizer.
  - Start detection: a high-to-low transition on the synced signal, re-checked at CLKS_PER_BIT/2. If the line is high again at that check, it is a false start: return to idle, no byte produced.
  - Data bits are sampled every CLKS_PER_BIT cycles from the mid-start point, LSB first, 8 bits, then the stop bit.
  - Stop bit sampled 1: byte strobe.
  - Stop bit sampled 0: framing-error strobe, no byte strobe.
- **Frame format:** `HEADER`, `SONG`, `LEN2`, `LEN1`, `LEN0` (big-endian byte count L), L data bytes, `CSUM` (XOR of all data bytes; initial value 0x00).
- **Frame FSM states:** IDLE, SONG, LEN2, LEN1, LEN0, DATA, CSUM.
  - IDLE: a byte equal to HEADER moves to SONG, sets `busy`, and clears `done` and `error`. Any other byte is ignored.
  - SONG: byte > 3 goes to ERR. Otherwise latch `song` and go to LEN2.
  - LEN2: bits [7:6] non-zero goes to ERR (L limited to 22 bits). Otherwise latch and go to LEN1.
  - LEN1 goes to LEN0.
  - LEN0: if L == 0, go to CSUM. Otherwise clear offset and the XOR accumulator, then go to DATA.
  - DATA: each byte is written at `{song, offset}`, XORed into the accumulator, and offset increments. After the L-th byte, go to CSUM.
  - CSUM: byte equal to the accumulator sets `done`. A mismatch sets `error`. Both clear `busy` and return to IDLE.
  - ERR (an action, not a state): set `error`, clear `busy`, return to IDLE. Nothing further is written for that frame.
- **Framing error:** a framing error while `busy` goes to ERR. While not busy it is ignored.
- **No rollback:** bytes already written before an abort remain in memory.
- A HEADER byte arriving mid-frame is plain data or length, not a restart.
- `done` and `error` are mutually exclusive. Both hold until the next accepted HEADER or reset.

## Timing
- **Reset values:** all outputs 0; FSM in IDLE; RX idle; synchronizer flops 1.
- **Stop-bit sample edge.** E is the clk edge at which the stop bit is sampled. Counting from the first synced falling edge, this is the 2nd synchronizer flop edge plus CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
- **Write strobe timing:**
  - A data byte with its stop sample at E gives `wr_en` = 1 exactly in the cycle after E.
  - `wr_addr` and `wr_data` are valid in that same cycle and hold until the next write.
  - `wr_en` is never high for two consecutive cycles.
- **Status update timing:** `busy`, `done`, `error` and `song` update in the cycle after E of the byte that causes the change.
- **Offset wrap:** offset is 22 bits. L = 0x3FFFFF writes offsets 0..0x3FFFFE; offset never wraps within a frame.
- **Back-to-back bytes:** a byte whose start bit follows the previous stop bit with no idle gap is received correctly. The next start search begins at the stop-bit sample.
- **Reset mid-frame:** outputs return to their reset values immediately. The partial frame is discarded with no further writes.

## Test plan
- **Nominal frame** (CLKS_PER_BIT=16): A5,01,00,00,03,11,22,44,77 -> three `wr_en` pulses at 0x400000/11, 0x400001/22, 0x400002/44; then `done`=1, `busy`=0, `song`=1, `error`=0.
- **Checksum mismatch:** same frame with CSUM=76 -> three writes issued, then `error`=1, `done`=0. A following A5 clears `error` and sets `busy`.
- **Invalid fields:** SONG=04 -> `error`=1 with no writes. Separately, LEN2=40 -> `error`=1 with no writes.
- **Zero length:** A5,02,00,00,00,00 -> no writes, `done`=1. CSUM=01 instead -> `error`=1.
- **Line faults:**
  - Stop bit forced 0 on the 2nd data byte -> exactly one write, then `error`=1.
  - A 3-cycle low glitch on idle `rx` -> no byte, FSM stays in IDLE.
- **Async reset after the 2nd data byte:** all outputs 0 immediately; re-sending the full nominal frame completes with `done`=1.
